// File: rtl/xy_step_pkg.sv
// Shared types and constants for the XY step engine.
package xy_step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DONE
    } state_t;

    localparam logic AXIS_X  = 1'b0;
    localparam logic AXIS_Y  = 1'b1;
    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/xy_step_engine_step_unit.sv
// Combinational single-axis stepper: one +/-step at W+1 bits with edge
// detection, then saturate or wrap depending on WRAP.
module step_unit
    import xy_step_pkg::*;
#(
    parameter int W      = 4,
    parameter int STEP_W = 2,
    parameter int WRAP   = 0
) (
    input  logic [W-1:0]      value,
    input  logic [STEP_W-1:0] step,
    input  logic              dir,
    output logic [W-1:0]      next_value,
    output logic              edge_flag
);

    logic [W:0] value_ext;
    logic [W:0] step_ext;
    logic [W:0] result;

    always_comb begin
        value_ext = {1'b0, value};
        step_ext  = (W+1)'(step);
        if (dir == DIR_DEC) begin
            result = value_ext - step_ext;
        end else begin
            result = value_ext + step_ext;
        end
        // Bit W is the carry on increment and the borrow on decrement.
        edge_flag  = result[W];
        next_value = result[W-1:0];
        if (edge_flag && (WRAP == 0)) begin
            next_value = (dir == DIR_DEC) ? '0 : '1;
        end
    end

endmodule

// File: rtl/xy_step_engine.sv
// Two-axis position register driven by repeated step commands, with load
// override, sticky edge detection and a done pulse per completed command.
module xy_step_engine
    import xy_step_pkg::*;
#(
    parameter int W      = 4,
    parameter int STEP_W = 2,
    parameter int CNT_W  = 4,
    parameter int WRAP   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [W-1:0]      load_x,
    input  logic [W-1:0]      load_y,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_axis,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic [W-1:0]      pos_x,
    output logic [W-1:0]      pos_y,
    output logic              busy,
    output logic              done,
    output logic              edge_hit
);

    state_t              state;
    logic                axis_q;
    logic                dir_q;
    logic [STEP_W-1:0]   step_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [W-1:0]        cur_value;
    logic [W-1:0]        next_value;
    logic                step_edge;

    assign cmd_ready = (state == ST_IDLE) && !load;
    assign cur_value = (axis_q == AXIS_Y) ? pos_y : pos_x;

    step_unit #(
        .W      (W),
        .STEP_W (STEP_W),
        .WRAP   (WRAP)
    ) u_step_unit (
        .value      (cur_value),
        .step       (step_q),
        .dir        (dir_q),
        .next_value (next_value),
        .edge_flag  (step_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pos_x    <= '0;
            pos_y    <= '0;
            axis_q   <= AXIS_X;
            dir_q    <= DIR_INC;
            step_q   <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            edge_hit <= 1'b0;
        end else if (load) begin
            // Load aborts whatever is in flight, without a done pulse.
            state    <= ST_IDLE;
            pos_x    <= load_x;
            pos_y    <= load_y;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            edge_hit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        axis_q   <= cmd_axis;
                        dir_q    <= cmd_dir;
                        step_q   <= cmd_step;
                        cnt_q    <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                        edge_hit <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (axis_q == AXIS_Y) begin
                        pos_y <= next_value;
                    end else begin
                        pos_x <= next_value;
                    end
                    if (step_edge) begin
                        edge_hit <= 1'b1;
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xy_step_engine.sv
// Scoreboard bench for xy_step_engine: one saturating and one wrapping instance.
module tb_xy_step_engine;
    import xy_step_pkg::*;

    localparam int W      = 4;
    localparam int STEP_W = 2;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              load;
        logic [W-1:0]      lx;
        logic [W-1:0]      ly;
        logic              valid;
        logic              axis;
        logic              dir;
        logic [STEP_W-1:0] step;
        logic [CNT_W-1:0]  count;
    } in_t;

    typedef struct packed {
        logic         ready;
        logic [W-1:0] px;
        logic [W-1:0] py;
        logic         busy;
        logic         done;
        logic         edge_hit;
    } out_t;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         busy;
        logic         done;
        logic         edge_hit;
        logic         ready;
    } trace_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    in_t    in_s  [2];
    out_t   out_s [2];
    trace_t q0 [$];
    trace_t q1 [$];
    int     n_pass = 0;
    int     n_total = 0;

    always #5 clk = ~clk;

    xy_step_engine #(.W(W), .STEP_W(STEP_W), .CNT_W(CNT_W), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .load(in_s[0].load), .load_x(in_s[0].lx), .load_y(in_s[0].ly),
        .cmd_valid(in_s[0].valid), .cmd_ready(out_s[0].ready),
        .cmd_axis(in_s[0].axis), .cmd_dir(in_s[0].dir),
        .cmd_step(in_s[0].step), .cmd_count(in_s[0].count),
        .pos_x(out_s[0].px), .pos_y(out_s[0].py),
        .busy(out_s[0].busy), .done(out_s[0].done), .edge_hit(out_s[0].edge_hit)
    );

    xy_step_engine #(.W(W), .STEP_W(STEP_W), .CNT_W(CNT_W), .WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .load(in_s[1].load), .load_x(in_s[1].lx), .load_y(in_s[1].ly),
        .cmd_valid(in_s[1].valid), .cmd_ready(out_s[1].ready),
        .cmd_axis(in_s[1].axis), .cmd_dir(in_s[1].dir),
        .cmd_step(in_s[1].step), .cmd_count(in_s[1].count),
        .pos_x(out_s[1].px), .pos_y(out_s[1].py),
        .busy(out_s[1].busy), .done(out_s[1].done), .edge_hit(out_s[1].edge_hit)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic trace_t tr(input int x, input int y, input bit b, input bit d, input bit e);
        tr = '{x: W'(x), y: W'(y), busy: b, done: d, edge_hit: e, ready: 1'b0};
    endfunction

    function automatic logic [31:0] observed(input out_t o);
        observed = 32'({o.px, o.py, o.busy, o.done, o.edge_hit, o.ready});
    endfunction

    // Monitors: every busy/done cycle must match the next expected trace entry.
    always @(negedge clk) begin
        if (rst_n && (out_s[0].busy || out_s[0].done)) begin
            if (q0.size() == 0) begin
                check("sat_unexpected_activity", 32'({out_s[0].busy, out_s[0].done}), 32'd0);
            end else begin
                check("sat_trace", observed(out_s[0]), 32'(q0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (out_s[1].busy || out_s[1].done)) begin
            if (q1.size() == 0) begin
                check("wrap_unexpected_activity", 32'({out_s[1].busy, out_s[1].done}), 32'd0);
            end else begin
                check("wrap_trace", observed(out_s[1]), 32'(q1.pop_front()));
            end
        end
    end

    task automatic issue(input int sel, input logic axis, input logic dir,
                         input int step, input int count);
        @(posedge clk); #1;
        in_s[sel].valid = 1'b1;
        in_s[sel].axis  = axis;
        in_s[sel].dir   = dir;
        in_s[sel].step  = STEP_W'(step);
        in_s[sel].count = CNT_W'(count);
        @(posedge clk); #1;
        in_s[sel].valid = 1'b0;
    endtask

    task automatic do_load(input int sel, input int x, input int y);
        @(posedge clk); #1;
        in_s[sel].load = 1'b1;
        in_s[sel].lx   = W'(x);
        in_s[sel].ly   = W'(y);
        @(posedge clk); #1;
        in_s[sel].load = 1'b0;
    endtask

    task automatic wait_ready(input int sel);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_s[sel].ready) seen = 1'b1;
        end
        if (!seen) check("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [8:0] ready_pat;
        in_s[0] = '0;
        in_s[1] = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_outputs", observed(out_s[0]) >> 1, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(out_s[0].ready), 32'd1);

        // x inc step 1 count 3 from origin
        q0.push_back(tr(0, 0, 1, 0, 0));
        q0.push_back(tr(1, 0, 1, 0, 0));
        q0.push_back(tr(2, 0, 1, 0, 0));
        q0.push_back(tr(3, 0, 0, 1, 0));
        issue(0, AXIS_X, DIR_INC, 1, 3);
        wait_ready(0);

        // saturation at the top edge, y untouched
        do_load(0, 14, 6);
        @(negedge clk);
        check("load_pos", 32'({out_s[0].px, out_s[0].py}), 32'h0000_00E6);
        q0.push_back(tr(14, 6, 1, 0, 0));
        q0.push_back(tr(15, 6, 1, 0, 1));
        q0.push_back(tr(15, 6, 0, 1, 1));
        issue(0, AXIS_X, DIR_INC, 3, 2);
        wait_ready(0);
        check("edge_hit_sticky", 32'(out_s[0].edge_hit), 32'd1);

        // load on the second MOVE cycle of a count-8 command aborts it
        q0.push_back(tr(15, 6, 1, 0, 0));
        q0.push_back(tr(15, 7, 1, 0, 0));
        issue(0, AXIS_Y, DIR_INC, 1, 8);
        @(posedge clk); #1;
        in_s[0].load = 1'b1;
        in_s[0].lx   = 4'd5;
        in_s[0].ly   = 4'd9;
        @(posedge clk); #1;
        in_s[0].load = 1'b0;
        @(negedge clk);
        check("abort_pos", 32'({out_s[0].px, out_s[0].py}), 32'h0000_0059);
        check("abort_ready", 32'(out_s[0].ready), 32'd1);
        check("abort_flags", 32'({out_s[0].busy, out_s[0].done, out_s[0].edge_hit}), 32'd0);
        repeat (12) @(negedge clk);

        // continuous cmd_valid with count 0: one repeat each, accept every 3 cycles
        for (int k = 0; k < 3; k++) begin
            q0.push_back(tr(5 - k, 9, 1, 0, 0));
            q0.push_back(tr(4 - k, 9, 0, 1, 0));
        end
        @(posedge clk); #1;
        in_s[0].valid = 1'b1;
        in_s[0].axis  = AXIS_X;
        in_s[0].dir   = DIR_DEC;
        in_s[0].step  = 2'd1;
        in_s[0].count = 4'd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ready_pat[i] = out_s[0].ready;
        end
        @(posedge clk); #1;
        in_s[0].valid = 1'b0;
        check("ready_pattern", 32'(ready_pat), 32'b001001001);
        wait_ready(0);

        // zero step runs full count with no motion
        q0.push_back(tr(2, 9, 1, 0, 0));
        q0.push_back(tr(2, 9, 1, 0, 0));
        q0.push_back(tr(2, 9, 0, 1, 0));
        issue(0, AXIS_Y, DIR_INC, 0, 2);
        wait_ready(0);

        // saturation at the bottom edge
        q0.push_back(tr(2, 9, 1, 0, 0));
        q0.push_back(tr(0, 9, 0, 1, 1));
        issue(0, AXIS_X, DIR_DEC, 3, 1);
        wait_ready(0);

        // asynchronous reset mid-MOVE
        q0.push_back(tr(0, 9, 1, 0, 0));
        q0.push_back(tr(1, 9, 1, 0, 0));
        issue(0, AXIS_X, DIR_INC, 1, 8);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", observed(out_s[0]) >> 1, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(out_s[0].ready), 32'd1);
        check("wrap_ready_after_release", 32'(out_s[1].ready), 32'd1);
        repeat (4) @(negedge clk);

        // wrapping instance: decrement below zero and increment past the top
        do_load(1, 0, 1);
        @(negedge clk);
        check("wrap_load_pos", 32'({out_s[1].px, out_s[1].py}), 32'h0000_0001);
        q1.push_back(tr(0, 1, 1, 0, 0));
        q1.push_back(tr(0, 15, 1, 0, 1));
        q1.push_back(tr(0, 13, 0, 1, 1));
        issue(1, AXIS_Y, DIR_DEC, 2, 2);
        wait_ready(1);
        check("wrap_edge_hit", 32'(out_s[1].edge_hit), 32'd1);

        do_load(1, 14, 13);
        q1.push_back(tr(14, 13, 1, 0, 0));
        q1.push_back(tr(1, 13, 0, 1, 1));
        issue(1, AXIS_X, DIR_INC, 3, 1);
        wait_ready(1);

        repeat (3) @(negedge clk);
        check("sat_queue_drained", 32'(q0.size()), 32'd0);
        check("wrap_queue_drained", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
